// File: rtl/game_sequencer.sv
// game_sequencer: three-stage memory game. The pattern is shown symbol by
// symbol on the LEDs, then the player must repeat it on the buttons before
// the idle timeout expires. Clearing stage 3 wins; a wrong press or a timeout
// loses.
//
//  state    | meaning
//  ---------+--------------------------------------------------
//  IDLE     | waiting for start after reset
//  SHOW_ON  | symbol[step] lit for SHOW_CYCLES cycles
//  SHOW_OFF | dark gap of GAP_CYCLES cycles after each symbol
//  INPUT    | waiting for the player to press symbol[step]
//  WIN      | stage 3 completed, held until start
//  LOSE     | wrong press or timeout, held until start
module game_sequencer #(
    parameter int SHOW_CYCLES    = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rstgame,
    input  logic       start,
    input  logic [3:0] button,
    input  logic [1:0] data1,
    input  logic [1:0] data2,
    input  logic [1:0] data3,
    output logic       stage1,
    output logic       stage2,
    output logic       stage3,
    output logic [3:0] led,
    output logic [1:0] step,
    output logic       busy,
    output logic       win,
    output logic       lose
);

    if (SHOW_CYCLES < 1 || SHOW_CYCLES > 255 ||
        GAP_CYCLES < 1 || GAP_CYCLES > 255 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_check
        $error("game_sequencer: cycle parameters must lie in 1..255");
    end

    localparam logic [7:0] SHOW_LAST    = 8'(SHOW_CYCLES - 1);
    localparam logic [7:0] GAP_LAST     = 8'(GAP_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SHOW_ON,
        SHOW_OFF,
        INPUT,
        WIN,
        LOSE
    } state_t;

    state_t     state;
    logic [2:0] stage;
    logic [7:0] cnt;
    logic [3:0] btn_q;
    logic [1:0] exp_sym;
    logic [3:0] exp_onehot;
    logic [1:0] last_step;
    logic       press;

    assign stage1 = stage[0];
    assign stage2 = stage[1];
    assign stage3 = stage[2];

    // Expected symbol for the current step, and the final step index of the stage.
    always_comb begin
        exp_sym = data3;
        case (step)
            2'd0:    exp_sym = data1;
            2'd1:    exp_sym = data2;
            default: exp_sym = data3;
        endcase
        last_step = 2'd2;
        if (stage[0])
            last_step = 2'd0;
        else if (stage[1])
            last_step = 2'd1;
    end

    assign exp_onehot = 4'b0001 << exp_sym;
    assign press      = (button != 4'b0000) && (btn_q == 4'b0000);

    // LED is decoded from the registered state but takes the symbol live from
    // the pattern source, which may re-select its data when the stage changes.
    always_comb begin
        led = 4'b0000;
        if (state == SHOW_ON)
            led = exp_onehot;
    end

    // Main sequencer: state, stage, step, counter, registered button and flags.
    always_ff @(posedge clk) begin
        if (rstgame) begin
            state <= IDLE;
            stage <= 3'b001;
            step  <= 2'd0;
            cnt   <= 8'd0;
            btn_q <= 4'b0000;
            busy  <= 1'b0;
            win   <= 1'b0;
            lose  <= 1'b0;
        end else begin
            btn_q <= button;
            case (state)
                IDLE, WIN, LOSE: begin
                    if (start) begin
                        state <= SHOW_ON;
                        stage <= 3'b001;
                        step  <= 2'd0;
                        cnt   <= 8'd0;
                        busy  <= 1'b1;
                        win   <= 1'b0;
                        lose  <= 1'b0;
                    end
                end
                SHOW_ON: begin
                    if (cnt == SHOW_LAST) begin
                        state <= SHOW_OFF;
                        cnt   <= 8'd0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                SHOW_OFF: begin
                    if (cnt == GAP_LAST) begin
                        cnt <= 8'd0;
                        if (step == last_step) begin
                            step  <= 2'd0;
                            state <= INPUT;
                        end else begin
                            step  <= step + 2'd1;
                            state <= SHOW_ON;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                INPUT: begin
                    // A press in the expiry cycle still counts as a press.
                    if (press) begin
                        if (button != exp_onehot) begin
                            state <= LOSE;
                            busy  <= 1'b0;
                            lose  <= 1'b1;
                        end else if (step != last_step) begin
                            step <= step + 2'd1;
                            cnt  <= 8'd0;
                        end else if (stage[2]) begin
                            state <= WIN;
                            busy  <= 1'b0;
                            win   <= 1'b1;
                        end else begin
                            stage <= {stage[1:0], 1'b0};
                            step  <= 2'd0;
                            cnt   <= 8'd0;
                            state <= SHOW_ON;
                        end
                    end else if (cnt == TIMEOUT_LAST) begin
                        state <= LOSE;
                        busy  <= 1'b0;
                        lose  <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Testbench for game_sequencer: directed scenarios plus randomized games
// checked against a transaction-level model of the game rules.
module tb_game_sequencer;

    localparam int SHOW = 4;
    localparam int GAP  = 2;
    localparam int TMO  = 16;

    logic       clk = 1'b0;
    logic       rstgame, start;
    logic [3:0] button;
    logic [1:0] data1, data2, data3;
    logic       stage1, stage2, stage3;
    logic [3:0] led;
    logic [1:0] step;
    logic       busy, win, lose;
    wire  [2:0] stg = {stage3, stage2, stage1};

    int errors = 0;
    int checks = 0;
    logic [1:0] pat [3];

    game_sequencer #(.SHOW_CYCLES(SHOW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rstgame(rstgame), .start(start), .button(button),
        .data1(data1), .data2(data2), .data3(data3),
        .stage1(stage1), .stage2(stage2), .stage3(stage3),
        .led(led), .step(step), .busy(busy), .win(win), .lose(lose)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [3:0] oh(input logic [1:0] v);
        return 4'b0001 << v;
    endfunction

    task automatic load_pattern(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
        pat[0] = a; pat[1] = b; pat[2] = c;
        data1 = a; data2 = b; data3 = c;
    endtask

    task automatic do_reset();
        rstgame = 1'b1; start = 1'b0; button = 4'b0000;
        tick();
        rstgame = 1'b0;
    endtask

    // Start a game and advance to the first INPUT cycle of stage 1.
    task automatic start_to_input();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (SHOW + GAP) tick();
    endtask

    task automatic test_reset();
        rstgame = 1'b1; start = 1'b1; button = 4'b0001;
        load_pattern(2'd0, 2'd0, 2'd0);
        tick();
        checks++;
        if (stg !== 3'b001 || led !== 4'b0000 || step !== 2'd0 ||
            busy !== 1'b0 || win !== 1'b0 || lose !== 1'b0) begin
            errors++;
            $display("FAIL reset: stage=%b led=%b step=%0d busy=%b win=%b lose=%b, want 001 0000 0 0 0 0",
                     stg, led, step, busy, win, lose);
        end
        rstgame = 1'b0; start = 1'b0; button = 4'b0000;
        tick();
        checks++;
        if (busy !== 1'b0 || stg !== 3'b001) begin
            errors++;
            $display("FAIL reset_idle_hold: busy=%b stage=%b, want 0 001", busy, stg);
        end
    endtask

    task automatic test_show_timing();
        load_pattern(2'd2, 2'd1, 2'd3);
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            checks++;
            if (led !== ((c <= 4) ? 4'b0100 : 4'b0000) || busy !== 1'b1) begin
                errors++;
                $display("FAIL show_timing cycle %0d: led=%b busy=%b, want %b 1",
                         c, led, busy, (c <= 4) ? 4'b0100 : 4'b0000);
            end
            tick();
        end
        checks++;
        if (busy !== 1'b1 || led !== 4'b0000 || step !== 2'd0 || lose !== 1'b0) begin
            errors++;
            $display("FAIL input_entry: busy=%b led=%b step=%0d lose=%b, want 1 0000 0 0", busy, led, step, lose);
        end
        // Correct stage-1 press moves straight to stage 2 display.
        button = 4'b0100;
        tick();
        button = 4'b0000;
        checks++;
        if (stg !== 3'b010 || led !== 4'b0100 || step !== 2'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stage2_entry: stage=%b led=%b step=%0d busy=%b, want 010 0100 0 1", stg, led, step, busy);
        end
        repeat (SHOW + GAP) tick();
        checks++;
        if (led !== 4'b0010 || step !== 2'd1) begin
            errors++;
            $display("FAIL stage2_second_symbol: led=%b step=%0d, want 0010 1", led, step);
        end
    endtask

    // Plays one game from IDLE/WIN/LOSE; in random mode picks per-step actions.
    task automatic play_game(input bit rnd, output bit won);
        logic [3:0] q_led [$];
        logic [3:0] exp_led, bv;
        bit done;
        int act, w;
        data1 = pat[0]; data2 = pat[1]; data3 = pat[2];
        won = 1'b0;
        done = 1'b0;
        start = 1'b1;
        tick();
        start = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        for (int n = 1; n <= 3 && !done; n++) begin
            q_led.delete();
            for (int k = 0; k < n; k++) begin
                repeat (SHOW) q_led.push_back(oh(pat[k]));
                repeat (GAP) q_led.push_back(4'b0000);
            end
            while (q_led.size() > 0) begin
                exp_led = q_led.pop_front();
                checks++;
                if (led !== exp_led || busy !== 1'b1 || stg !== 3'(3'b001 << (n - 1))) begin
                    errors++;
                    $display("FAIL show stage %0d: led=%b busy=%b stage=%b, want %b 1 %b",
                             n, led, busy, stg, exp_led, 3'(3'b001 << (n - 1)));
                end
                button = rnd ? 4'($urandom_range(0, 15)) : 4'b0000;
                tick();
            end
            button = 4'b0000;
            for (int k = 0; k < n && !done; k++) begin
                act = rnd ? int'($urandom_range(0, 19)) : 0;
                if (act == 19) begin
                    for (int j = 0; j < TMO; j++) begin
                        checks++;
                        if (lose !== 1'b0 || busy !== 1'b1 || step !== 2'(k)) begin
                            errors++;
                            $display("FAIL timeout_wait %0d: lose=%b busy=%b step=%0d, want 0 1 %0d", j, lose, busy, step, k);
                        end
                        button = 4'b0000;
                        tick();
                    end
                    checks++;
                    if (lose !== 1'b1 || busy !== 1'b0 || led !== 4'b0000) begin
                        errors++;
                        $display("FAIL timeout_lose: lose=%b busy=%b led=%b, want 1 0 0000", lose, busy, led);
                    end
                    done = 1'b1;
                end else begin
                    w = rnd ? int'($urandom_range(1, TMO - 1)) : 1;
                    for (int j = 0; j < w; j++) begin
                        checks++;
                        if (busy !== 1'b1 || lose !== 1'b0 || step !== 2'(k) || led !== 4'b0000) begin
                            errors++;
                            $display("FAIL input_wait: busy=%b lose=%b step=%0d led=%b, want 1 0 %0d 0000", busy, lose, step, led, k);
                        end
                        button = 4'b0000;
                        tick();
                    end
                    if (act == 18) begin
                        bv = 4'($urandom_range(1, 15));
                        if (bv == oh(pat[k])) bv = bv ^ 4'b1001;
                    end else begin
                        bv = oh(pat[k]);
                    end
                    button = bv;
                    tick();
                    button = 4'b0000;
                    if (act == 18) begin
                        checks++;
                        if (lose !== 1'b1 || busy !== 1'b0) begin
                            errors++;
                            $display("FAIL wrong_press %b: lose=%b busy=%b, want 1 0", bv, lose, busy);
                        end
                        done = 1'b1;
                    end else if (k < n - 1) begin
                        checks++;
                        if (step !== 2'(k + 1) || busy !== 1'b1 || lose !== 1'b0) begin
                            errors++;
                            $display("FAIL step_advance: step=%0d busy=%b lose=%b, want %0d 1 0", step, busy, lose, k + 1);
                        end
                    end else if (n == 3) begin
                        checks++;
                        if (win !== 1'b1 || busy !== 1'b0 || lose !== 1'b0) begin
                            errors++;
                            $display("FAIL win: win=%b busy=%b lose=%b, want 1 0 0", win, busy, lose);
                        end
                        won = 1'b1;
                        done = 1'b1;
                    end
                end
            end
        end
        start = 1'b0;
        repeat (3) begin
            tick();
            checks++;
            if (win !== won || lose !== !won || busy !== 1'b0 || led !== 4'b0000) begin
                errors++;
                $display("FAIL end_hold: win=%b lose=%b busy=%b led=%b, want %b %b 0 0000", win, lose, busy, led, won, !won);
            end
        end
    endtask

    task automatic test_full_game();
        bit won;
        load_pattern(2'd2, 2'd1, 2'd3);
        do_reset();
        play_game(1'b0, won);
        checks++;
        if (won !== 1'b1) begin
            errors++;
            $display("FAIL full_game: won=%b, want 1", won);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || win !== 1'b0 || stg !== 3'b001 || led !== 4'b0100 || step !== 2'd0) begin
            errors++;
            $display("FAIL restart_from_win: busy=%b win=%b stage=%b led=%b step=%0d, want 1 0 001 0100 0",
                     busy, win, stg, led, step);
        end
    endtask

    task automatic test_wrong_press();
        logic [3:0] bad [2];
        bad[0] = 4'b1000;
        bad[1] = 4'b0011;
        load_pattern(2'd1, 2'd0, 2'd0);
        do_reset();
        for (int i = 0; i < 2; i++) begin
            start_to_input();
            button = bad[i];
            tick();
            button = 4'b0000;
            checks++;
            if (lose !== 1'b1 || busy !== 1'b0 || led !== 4'b0000) begin
                errors++;
                $display("FAIL wrong_press_%b: lose=%b busy=%b led=%b, want 1 0 0000", bad[i], lose, busy, led);
            end
        end
    endtask

    task automatic test_timeout();
        load_pattern(2'd3, 2'd0, 2'd0);
        do_reset();
        start_to_input();
        for (int j = 0; j < TMO - 1; j++) begin
            button = 4'b0000;
            tick();
        end
        checks++;
        if (lose !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_edge_wait: lose=%b busy=%b, want 0 1", lose, busy);
        end
        button = 4'b1000;
        tick();
        button = 4'b0000;
        checks++;
        if (lose !== 1'b0 || stg !== 3'b010 || busy !== 1'b1) begin
            errors++;
            $display("FAIL press_at_expiry: lose=%b stage=%b busy=%b, want 0 010 1", lose, stg, busy);
        end
        do_reset();
        start_to_input();
        for (int j = 0; j < TMO; j++) begin
            checks++;
            if (lose !== 1'b0) begin
                errors++;
                $display("FAIL timeout_early %0d: lose=%b, want 0", j, lose);
            end
            tick();
        end
        checks++;
        if (lose !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_lose: lose=%b busy=%b, want 1 0", lose, busy);
        end
    endtask

    task automatic test_held_button();
        load_pattern(2'd0, 2'd0, 2'd0);
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        button = 4'b1000;
        tick();
        button = 4'b0000;
        repeat (SHOW + GAP - 3) tick();
        button = 4'b0001;
        tick();
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (busy !== 1'b1 || lose !== 1'b0 || stg !== 3'b001 || step !== 2'd0) begin
                errors++;
                $display("FAIL held_button %0d: busy=%b lose=%b stage=%b step=%0d, want 1 0 001 0", j, busy, lose, stg, step);
            end
            tick();
        end
        button = 4'b0000;
        tick();
        button = 4'b0001;
        tick();
        button = 4'b0000;
        checks++;
        if (stg !== 3'b010 || lose !== 1'b0) begin
            errors++;
            $display("FAIL repress_after_release: stage=%b lose=%b, want 010 0", stg, lose);
        end
    endtask

    task automatic test_reset_mid_show();
        load_pattern(2'd2, 2'd1, 2'd0);
        do_reset();
        start_to_input();
        button = 4'b0100;
        tick();
        button = 4'b0000;
        repeat (SHOW) tick();
        checks++;
        if (stg !== 3'b010 || led !== 4'b0000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stage2_gap: stage=%b led=%b busy=%b, want 010 0000 1", stg, led, busy);
        end
        rstgame = 1'b1;
        start = 1'b1;
        tick();
        rstgame = 1'b0;
        start = 1'b0;
        checks++;
        if (stg !== 3'b001 || led !== 4'b0000 || step !== 2'd0 || busy !== 1'b0 || win !== 1'b0 || lose !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_show: stage=%b led=%b step=%0d busy=%b win=%b lose=%b, want 001 0000 0 0 0 0",
                     stg, led, step, busy, win, lose);
        end
    endtask

    task automatic test_random_games();
        bit won;
        do_reset();
        for (int g = 0; g < 30; g++) begin
            if ($urandom_range(0, 3) == 0) do_reset();
            load_pattern(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            play_game(1'b1, won);
        end
    endtask

    initial begin
        rstgame = 1'b1; start = 1'b0; button = 4'b0000;
        data1 = 2'd0; data2 = 2'd0; data3 = 2'd0;
        @(negedge clk);
        test_reset();
        test_show_timing();
        test_full_game();
        test_wrong_press();
        test_timeout();
        test_held_button();
        test_reset_mid_show();
        test_random_games();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
